// File: rtl/uart.sv
// UART, 8N1, full duplex, single clock domain.
//
// Parameters:
//   CLK_FREQ  - clock frequency in Hz
//   BAUD_RATE - line bit rate in bits/s; one bit lasts CLK_FREQ/BAUD_RATE cycles (truncated).
//               The resulting bit period must be at least 2 cycles.
// Ports:
//   clk, rst                  - clock and asynchronous active-low reset
//   uart_rd_data/valid/ready  - received byte stream (valid held until a ready edge)
//   uart_wr_data/valid/ready  - byte stream to transmit (accepted on valid & ready)
//   uart_rxd                  - serial input, asynchronous, idle high
//   uart_txd                  - serial output, registered, idle high
// Build option:
//   UART_LOOPBACK_EN - when defined, the receiver listens to the internal registered TX line
//                      and uart_rxd is ignored; uart_txd is still driven normally.
module uart #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] uart_rd_data,
  output logic       uart_rd_valid,
  input  logic       uart_rd_ready,
  input  logic [7:0] uart_wr_data,
  input  logic       uart_wr_valid,
  output logic       uart_wr_ready,
  input  logic       uart_rxd,
  output logic       uart_txd
);

  localparam int unsigned Div  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned Half = Div / 2;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(Half - 1);

  // ---------------------------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_idx_q, tx_idx_d;
  logic [7:0]      tx_sh_q, tx_sh_d;
  logic            tx_txd_q, tx_txd_d;
  logic            tx_ready_q, tx_ready_d;
  logic            tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == CntLast);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_sh_d    = tx_sh_q;
    tx_txd_d   = tx_txd_q;
    tx_ready_d = tx_ready_q;
    unique case (tx_state_q)
      TxIdle: begin
        tx_txd_d   = 1'b1;
        tx_ready_d = 1'b1;
        if (uart_wr_valid && tx_ready_q) begin
          tx_state_d = TxStart;
          tx_cnt_d   = '0;
          tx_sh_d    = uart_wr_data;
          tx_txd_d   = 1'b0;
          tx_ready_d = 1'b0;
        end
      end
      TxStart: begin
        if (tx_bit_end) begin
          tx_state_d = TxData;
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_txd_d   = tx_sh_q[0];
          tx_sh_d    = {1'b0, tx_sh_q[7:1]};
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_state_d = TxStop;
            tx_txd_d   = 1'b1;
          end else begin
            tx_idx_d = tx_idx_q + 3'd1;
            tx_txd_d = tx_sh_q[0];
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxStop: begin
        if (tx_bit_end) begin
          tx_state_d = TxIdle;
          tx_cnt_d   = '0;
          tx_ready_d = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_state_d = TxIdle;
        tx_txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_sh_q    <= '0;
      tx_txd_q   <= 1'b1;
      tx_ready_q <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_sh_q    <= tx_sh_d;
      tx_txd_q   <= tx_txd_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  assign uart_txd      = tx_txd_q;
  assign uart_wr_ready = tx_ready_q;

  // ---------------------------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------------------------
  logic rx_src;

`ifdef UART_LOOPBACK_EN
  logic unused_rxd;
  assign unused_rxd = uart_rxd;
  assign rx_src     = tx_txd_q;
`else
  assign rx_src = uart_rxd;
`endif

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  logic [1:0]      rx_sync_q;
  logic            rx_prev_q;
  logic            rx_s;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_idx_q, rx_idx_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  // Set after a bad stop bit: stay in RxStop until the line is seen high again.
  logic            rx_ferr_q, rx_ferr_d;
  logic            rx_done;
  logic            rx_bit_end;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;

  assign rx_s       = rx_sync_q[1];
  assign rx_bit_end = (rx_cnt_q == CntLast);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_sh_d    = rx_sh_q;
    rx_ferr_d  = rx_ferr_q;
    rx_done    = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        // Mid-start-bit re-check rejects short low glitches.
        if (rx_cnt_q == CntHalf) begin
          rx_cnt_d   = '0;
          rx_idx_d   = '0;
          rx_state_d = rx_s ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_bit_end) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s, rx_sh_q[7:1]};
          if (rx_idx_q == 3'd7) begin
            rx_state_d = RxStop;
            rx_ferr_d  = 1'b0;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_ferr_q) begin
          if (rx_s) begin
            rx_state_d = RxIdle;
            rx_ferr_d  = 1'b0;
          end
        end else if (rx_bit_end) begin
          rx_cnt_d = '0;
          if (rx_s) begin
            rx_done    = 1'b1;
            rx_state_d = RxIdle;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Output holding register: a completed byte is taken only if the slot is free or being
  // consumed on this same edge; otherwise it is an overrun and dropped.
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (rx_done && (!rd_valid_q || uart_rd_ready)) begin
      rd_data_d  = rx_sh_q;
      rd_valid_d = 1'b1;
    end else if (rd_valid_q && uart_rd_ready) begin
      rd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_sh_q    <= '0;
      rx_ferr_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rx_src};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_sh_q    <= rx_sh_d;
      rx_ferr_q  <= rx_ferr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign uart_rd_data  = rd_data_q;
  assign uart_rd_valid = rd_valid_q;

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart. Uses a short bit period (43 cycles, from truncating
// 1_000_000 / 23_000) so that whole frames fit in a short run; the glitch test scales its
// pulse to a third of a bit. The expected line waveform is built from the 8N1 frame rule and
// received bytes are compared against a queue of the bytes that were sent.
module tb_uart;

  localparam int unsigned ClkFreq  = 1_000_000;
  localparam int unsigned BaudRate = 23_000;
  localparam int unsigned Div      = ClkFreq / BaudRate;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b1;
  logic [7:0] wr_data  = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       rxd;
  logic       txd;
  logic       loop_en = 1'b0;
  logic       rxd_drv = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];

  assign rxd = loop_en ? txd : rxd_drv;

  uart #(
    .CLK_FREQ (ClkFreq),
    .BAUD_RATE(BaudRate)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rd_data (rd_data),
    .uart_rd_valid(rd_valid),
    .uart_rd_ready(rd_ready),
    .uart_wr_data (wr_data),
    .uart_wr_valid(wr_valid),
    .uart_wr_ready(wr_ready),
    .uart_rxd     (rxd),
    .uart_txd     (txd)
  );

  always #5 clk = ~clk;

  // Every handshake (valid & ready at the coming edge) delivers one byte.
  always @(negedge clk) begin
    if (rst && rd_valid && rd_ready) rx_q.push_back(rd_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a byte and return one step after the edge that accepts it.
  task automatic tx_send(input logic [7:0] d);
    int n = 0;
    wr_data  = d;
    wr_valid = 1'b1;
    while (wr_ready !== 1'b1 && n < 20 * Div) begin
      tick(1);
      n++;
    end
    if (n >= 20 * Div) check("tx_accept_timeout", 32'd0, 32'd1);
    tick(1);
    wr_valid = 1'b0;
  endtask

  // Send a byte and compare the line, bit by bit, against the 8N1 frame.
  task automatic tx_check(input logic [7:0] d);
    logic [9:0] frame;
    int         rdy_bad = 0;
    frame = {1'b1, d, 1'b0};
    tx_send(d);
    for (int b = 0; b < 10; b++) begin
      int bad = 0;
      for (int c = 0; c < int'(Div); c++) begin
        if (txd !== frame[b]) bad++;
        if (wr_ready !== 1'b0) rdy_bad++;
        tick(1);
      end
      check($sformatf("tx_%02h_bit%0d", d, b), bad, 0);
    end
    check("tx_ready_busy", rdy_bad, 0);
    check("tx_ready_after", {31'd0, wr_ready}, 1);
    check("tx_idle_line", {31'd0, txd}, 1);
  endtask

  // Drive one frame on the serial input with a chosen stop-bit value.
  task automatic rx_drive(input logic [7:0] d, input logic stop);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rxd_drv = frame[b];
      tick(Div);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    string      hello;
    logic [7:0] b;
    hello = "Hello, world";

    // Reset state
    tick(3);
    check("rst_txd", {31'd0, txd}, 1);
    check("rst_wr_ready", {31'd0, wr_ready}, 0);
    check("rst_rd_valid", {31'd0, rd_valid}, 0);
    check("rst_rd_data", {24'd0, rd_data}, 0);
    rst = 1'b1;
    tick(1);
    check("wr_ready_after_reset", {31'd0, wr_ready}, 1);

    // Transmit waveform: fixed byte then random bytes
    tx_check(8'h48);
    for (int i = 0; i < 2; i++) tx_check(8'($urandom));

    // Back-to-back string through an external loopback
    loop_en = 1'b1;
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < hello.len(); i++) begin
      exp_q.push_back(hello[i]);
      tx_send(hello[i]);
    end
    tick(12 * Div);
    check_rx("hello");
    check("hello_wr_ready_end", {31'd0, wr_ready}, 1);

    // Random bytes with random idle gaps, still looped back
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      tx_send(b);
      tick($urandom_range(0, Div));
    end
    tick(12 * Div);
    check_rx("rand_loop");
    loop_en = 1'b0;

    // Framing error, then a good frame
    rx_q.delete();
    exp_q.delete();
    rx_drive(8'hA5, 1'b0);
    tick(2 * Div);
    rx_drive(8'h3C, 1'b1);
    tick(2 * Div);
    exp_q.push_back(8'h3C);
    check_rx("framing");

    // Short low glitch, then a good frame
    rx_q.delete();
    exp_q.delete();
    rxd_drv = 1'b0;
    tick(Div / 3);
    rxd_drv = 1'b1;
    tick(2 * Div);
    check("glitch_no_byte", rx_q.size(), 0);
    check("glitch_no_valid", {31'd0, rd_valid}, 0);
    rx_drive(8'h5A, 1'b1);
    tick(2 * Div);
    exp_q.push_back(8'h5A);
    check_rx("after_glitch");

    // Overrun: second byte dropped while the first is held
    rx_q.delete();
    exp_q.delete();
    rd_ready = 1'b0;
    rx_drive(8'h11, 1'b1);
    tick(Div);
    rx_drive(8'h22, 1'b1);
    tick(2 * Div);
    check("ovr_valid_held", {31'd0, rd_valid}, 1);
    check("ovr_data_held", {24'd0, rd_data}, 32'h11);
    rd_ready = 1'b1;
    tick(1);
    check("ovr_valid_cleared", {31'd0, rd_valid}, 0);
    tick(2 * Div);
    exp_q.push_back(8'h11);
    check_rx("overrun");

    // Random frames driven directly on the serial input
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      rx_drive(b, 1'b1);
      tick($urandom_range(1, Div));
    end
    tick(2 * Div);
    check_rx("rand_rx");

    // Reset in the middle of a transmitted data bit, with the line looped back
    loop_en = 1'b1;
    rx_q.delete();
    exp_q.delete();
    tx_send(8'h00);
    tick(3 * Div);
    check("mid_frame_txd_low", {31'd0, txd}, 0);
    rst = 1'b0;
    #1;
    check("abort_txd_high", {31'd0, txd}, 1);
    check("abort_wr_ready", {31'd0, wr_ready}, 0);
    check("abort_rd_valid", {31'd0, rd_valid}, 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("abort_ready_after_release", {31'd0, wr_ready}, 1);
    tick(12 * Div);
    check("abort_partial_discarded", rx_q.size(), 0);
    tx_send(8'hC3);
    tick(12 * Div);
    exp_q.push_back(8'hC3);
    check_rx("after_abort");
    loop_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate in bits/s.
REQ-003 clk  in  1  single clock; all logic in this domain.
REQ-004 rst  in  1  reset is asynchronous and active-low.
REQ-005 uart_rd_data  out  8  received byte.
REQ-006 uart_rd_valid  out  1  uart_rd_data holds an unconsumed byte.
REQ-007 uart_rd_ready  in  1  consumer accepts the byte.
REQ-008 uart_wr_data  in  8  byte to transmit.
REQ-009 uart_wr_valid  in  1  uart_wr_data is valid.
REQ-010 uart_wr_ready  out  1  transmitter can accept a byte.
REQ-011 uart_rxd  in  1  serial input, asynchronous, idle high.
REQ-012 uart_txd  out  1  serial output, idle high.

Function
REQ-013 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-014 Bit period SHALL be DIV = CLK_FREQ/BAUD_RATE clk cycles, integer truncation (868 at defaults); counter width derived from DIV.
REQ-015 TX states SHALL be IDLE, START, DATA, STOP; IDLE->START on accept, START->DATA after DIV, DATA->STOP after 8 bits of DIV, STOP->IDLE after DIV.
REQ-016 A byte SHALL be accepted on a rising clk edge with uart_wr_valid=1 and uart_wr_ready=1; uart_wr_data is latched at that edge.
REQ-017 uart_wr_ready SHALL be 1 only in IDLE; it drops on the cycle after acceptance and returns to 1 the cycle after the stop bit's DIV cycles complete.
REQ-018 uart_txd SHALL drive the start bit starting the cycle after acceptance; uart_txd SHALL be registered (glitch-free).
REQ-019 uart_wr_valid with uart_wr_ready=0 SHALL be ignored; the source must hold data and valid until accepted.
REQ-020 uart_rxd SHALL pass through a 2-flop synchronizer before use.
REQ-021 RX states SHALL be IDLE, START, DATA, STOP; IDLE->START on a synchronized 1->0 edge.
REQ-022 START SHALL re-sample at DIV/2; a 1 returns to IDLE (glitch rejection), a 0 proceeds to DATA.
REQ-023 Data bits SHALL be sampled at bit centres (every DIV cycles after the start-bit centre), LSB first.
REQ-024 Stop bit sampled at its centre: 1 -> byte loaded to uart_rd_data, uart_rd_valid=1 next cycle; 0 -> framing error, byte discarded, RX waits for rxd=1 before IDLE.
REQ-025 uart_rd_valid SHALL stay 1 and uart_rd_data stable until a clk edge with uart_rd_ready=1; uart_rd_valid clears the following cycle.
REQ-026 Overrun: a new byte completing while uart_rd_valid=1 and uart_rd_ready=0 SHALL be dropped; the held byte is kept.
REQ-027 Simultaneous consume and new-byte completion on the same edge SHALL load the new byte with uart_rd_valid remaining 1.
REQ-028 TX and RX SHALL operate independently and full-duplex.

Reset
REQ-029 During reset: uart_txd=1, uart_wr_ready=0, uart_rd_valid=0, uart_rd_data=0x00, both FSMs IDLE, counters 0, synchronizer flops 1.
REQ-030 uart_wr_ready SHALL become 1 on the first clk edge after reset deassertion.
REQ-031 Reset mid-frame SHALL abort immediately: uart_txd returns to 1 and any partial RX byte is discarded.

Configuration
REQ-032 Macro UART_LOOPBACK_EN defined: RX input is the internal registered TX line instead of uart_rxd (uart_rxd ignored); uart_txd still driven normally.
REQ-033 UART_LOOPBACK_EN undefined: RX input is uart_rxd; no loopback logic synthesized.

Verification
REQ-034 Write 0x48 after reset -> uart_txd: 0 for 868 cycles, then bits 0,0,0,1,0,0,1,0 at 868 cycles each, then 1; uart_wr_ready low 8680 cycles.
REQ-035 Write "Hello, world" (12 bytes) back-to-back with loopback to uart_rxd, uart_rd_ready=1 -> 12 uart_rd_valid pulses carrying the same bytes in order; uart_wr_ready=1 at end.
REQ-036 Drive uart_rxd frame for 0xA5 with stop bit 0 -> no uart_rd_valid; following valid 0x3C frame received correctly.
REQ-037 uart_rd_ready=0, send 0x11 then 0x22 -> uart_rd_valid=1 with 0x11 held; 0x22 dropped.
REQ-038 0 pulse on uart_rxd of 200 cycles -> no byte received, RX back in IDLE.
REQ-039 Assert rst during DATA of a TX frame -> uart_txd=1 immediately; uart_wr_ready=1 one cycle after release.
